cbm_state_decoder: RTL and testbench

Downstream neighbour of the CBM encoder stage. It consumes the one-bit-per-neuron encoded inout-state stream (NI+NO lanes) and decodes it back into multi-bit state values. Each lane's ones are counted over a fixed window of accepted beats, and one WR-bit count per lane is emitted per window. It re-creates the WR-bit state vector that readout/learning stages expect.

---
 rtl/cbm_state_decoder_if.sv | 32 +++
 rtl/cbm_state_decoder.sv | 74 +++++++
 tb/tb_cbm_state_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cbm_state_decoder_if.sv
// rtl/cbm_state_decoder_if.sv - encoded-state input and decoded-state output handshake bundle
interface cbm_state_decoder_if #(
    parameter int WIDTH = 8,
    parameter int WR    = 8
);
    logic                  iValid_AS_EnInoutState;
    logic                  oReady_AS_EnInoutState;
    logic [WIDTH-1:0]      iData_AS_EnInoutState;
    logic                  oValid_BM_DecState;
    logic                  iReady_BM_DecState;
    logic [WIDTH*WR-1:0]   oData_BM_DecState;

    // master: the environment around the decoder (producer of beats, consumer of results)
    modport master (
        output iValid_AS_EnInoutState,
        output iData_AS_EnInoutState,
        output iReady_BM_DecState,
        input  oReady_AS_EnInoutState,
        input  oValid_BM_DecState,
        input  oData_BM_DecState
    );

    // slave: the decoder itself
    modport slave (
        input  iValid_AS_EnInoutState,
        input  iData_AS_EnInoutState,
        input  iReady_BM_DecState,
        output oReady_AS_EnInoutState,
        output oValid_BM_DecState,
        output oData_BM_DecState
    );
endinterface

// File: rtl/cbm_state_decoder.sv
// rtl/cbm_state_decoder.sv - counts ones per lane over a window of beats into WR-bit state values
module cbm_state_decoder #(
    parameter int WIDTH  = 8,
    parameter int WR     = 8,
    parameter int WINDOW = 255
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    cbm_state_decoder_if.slave    bus
);
    localparam int              CNT_W     = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

    logic [WIDTH-1:0][WR-1:0] acc_q, acc_d;
    logic [WIDTH-1:0][WR-1:0] lane_sum;
    logic [CNT_W-1:0]         beat_q, beat_d;
    logic [WIDTH*WR-1:0]      out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     last_beat;
    logic                     in_ready;
    logic                     accept;
    logic                     transfer;

    assign last_beat = (beat_q == LAST_BEAT);
    // Only the closing beat needs the output register, so only it waits for a drain.
    assign in_ready  = !(last_beat && valid_q && !bus.iReady_BM_DecState);
    assign accept    = bus.iValid_AS_EnInoutState && in_ready;
    assign transfer  = valid_q && bus.iReady_BM_DecState;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            lane_sum[k] = acc_q[k] + WR'(bus.iData_AS_EnInoutState[k]);
        end
    end

    always_comb begin
        acc_d   = acc_q;
        beat_d  = beat_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (transfer) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (last_beat) begin
                out_d   = lane_sum;
                valid_d = 1'b1;
                acc_d   = '0;
                beat_d  = '0;
            end else begin
                acc_d   = lane_sum;
                beat_d  = beat_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            acc_q   <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.oReady_AS_EnInoutState = in_ready;
    assign bus.oValid_BM_DecState     = valid_q;
    assign bus.oData_BM_DecState      = out_q;
endmodule

// File: tb/tb_cbm_state_decoder.sv
// tb/tb_cbm_state_decoder.sv - directed bench for cbm_state_decoder (WINDOW=15 and WINDOW=1)
module tb_cbm_state_decoder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    cbm_state_decoder_if #(.WIDTH(4), .WR(4)) bus_a ();
    cbm_state_decoder_if #(.WIDTH(4), .WR(4)) bus_b ();

    cbm_state_decoder #(.WIDTH(4), .WR(4), .WINDOW(15)) dut_a (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bus_a)
    );

    cbm_state_decoder #(.WIDTH(4), .WR(4), .WINDOW(1)) dut_b (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [15:0] d, input logic r);
        chk({tag, "_valid"}, 64'(bus_a.oValid_BM_DecState), 64'(v));
        chk({tag, "_data"},  64'(bus_a.oData_BM_DecState),  64'(d));
        chk({tag, "_ready"}, 64'(bus_a.oReady_AS_EnInoutState), 64'(r));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          cyc;
        int          b;
        logic        v;
        logic [3:0]  d;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus_a.iValid_AS_EnInoutState = 1'b0;
        bus_a.iData_AS_EnInoutState  = 4'h0;
        bus_a.iReady_BM_DecState     = 1'b1;
        bus_b.iValid_AS_EnInoutState = 1'b0;
        bus_b.iData_AS_EnInoutState  = 4'h0;
        bus_b.iReady_BM_DecState     = 1'b1;

        // reset state
        tick();
        chk_a("rst_in", 1'b0, 16'h0000, 1'b1);
        chk("rst_b_ready", 64'(bus_b.oReady_AS_EnInoutState), 64'd1);
        chk("rst_b_valid", 64'(bus_b.oValid_BM_DecState), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_a("rst_out", 1'b0, 16'h0000, 1'b1);
        tick();

        // full window
        for (int i = 0; i < 15; i++) begin
            bus_a.iValid_AS_EnInoutState = 1'b1;
            bus_a.iData_AS_EnInoutState  = 4'hF;
            #1;
            chk("full_pre_valid", 64'(bus_a.oValid_BM_DecState), 64'd0);
            tick();
        end
        bus_a.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk_a("full_out", 1'b1, 16'hFFFF, 1'b1);
        tick();
        chk("full_pulse_end", 64'(bus_a.oValid_BM_DecState), 64'd0);

        // mixed window
        for (int i = 0; i < 15; i++) begin
            b = i + 1;
            d[0] = 1'b1;
            d[1] = 1'b0;
            d[2] = (b % 2 == 1);
            d[3] = (b <= 3);
            bus_a.iValid_AS_EnInoutState = 1'b1;
            bus_a.iData_AS_EnInoutState  = d;
            tick();
        end
        bus_a.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk_a("mixed_out", 1'b1, 16'h380F, 1'b1);
        tick();
        chk("mixed_end", 64'(bus_a.oValid_BM_DecState), 64'd0);

        // gaps in iValid
        n = 0;
        cyc = 0;
        while (n < 15 && cyc < 300) begin
            v = 1'($urandom_range(0, 1));
            bus_a.iValid_AS_EnInoutState = v;
            bus_a.iData_AS_EnInoutState  = 4'hF;
            #1;
            chk("gap_pre_valid", 64'(bus_a.oValid_BM_DecState), 64'd0);
            tick();
            if (v) n++;
            cyc++;
        end
        chk("gap_accept_budget", 64'(n), 64'd15);
        bus_a.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk_a("gap_out", 1'b1, 16'hFFFF, 1'b1);
        tick();
        chk("gap_end", 64'(bus_a.oValid_BM_DecState), 64'd0);

        // backpressure across two windows of 4'h1
        bus_a.iReady_BM_DecState = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus_a.iValid_AS_EnInoutState = 1'b1;
            bus_a.iData_AS_EnInoutState  = 4'h1;
            #1;
            chk("bp_w1_ready", 64'(bus_a.oReady_AS_EnInoutState), 64'd1);
            tick();
        end
        for (int i = 0; i < 14; i++) begin
            #1;
            chk_a("bp_w2", 1'b1, 16'h000F, 1'b1);
            tick();
        end
        #1;
        chk_a("bp_stall", 1'b1, 16'h000F, 1'b0);
        tick();
        chk_a("bp_stall_hold", 1'b1, 16'h000F, 1'b0);
        bus_a.iReady_BM_DecState = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus_a.oReady_AS_EnInoutState), 64'd1);
        tick();
        bus_a.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk_a("bp_second", 1'b1, 16'h000F, 1'b1);
        tick();
        chk("bp_end", 64'(bus_a.oValid_BM_DecState), 64'd0);

        // reset mid-run with a pending result and a partial window
        bus_a.iReady_BM_DecState = 1'b0;
        for (int i = 0; i < 22; i++) begin
            bus_a.iValid_AS_EnInoutState = 1'b1;
            bus_a.iData_AS_EnInoutState  = 4'hF;
            tick();
        end
        bus_a.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk_a("mr_pending", 1'b1, 16'hFFFF, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_a("mr_async", 1'b0, 16'h0000, 1'b1);
        tick();
        rst_n = 1'b1;
        bus_a.iReady_BM_DecState = 1'b1;
        #1;
        chk_a("mr_release", 1'b0, 16'h0000, 1'b1);
        tick();
        for (int i = 0; i < 15; i++) begin
            bus_a.iValid_AS_EnInoutState = 1'b1;
            bus_a.iData_AS_EnInoutState  = 4'h3;
            #1;
            chk("mr_pre_valid", 64'(bus_a.oValid_BM_DecState), 64'd0);
            tick();
        end
        bus_a.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk_a("mr_out", 1'b1, 16'h00FF, 1'b1);
        tick();
        chk("mr_end", 64'(bus_a.oValid_BM_DecState), 64'd0);

        // WINDOW=1 instance
        bus_b.iValid_AS_EnInoutState = 1'b1;
        bus_b.iData_AS_EnInoutState  = 4'hA;
        #1;
        chk("w1_pre_valid", 64'(bus_b.oValid_BM_DecState), 64'd0);
        chk("w1_ready0", 64'(bus_b.oReady_AS_EnInoutState), 64'd1);
        tick();
        bus_b.iData_AS_EnInoutState = 4'h5;
        #1;
        chk("w1_out1_valid", 64'(bus_b.oValid_BM_DecState), 64'd1);
        chk("w1_out1_data", 64'(bus_b.oData_BM_DecState), 64'h1010);
        chk("w1_ready1", 64'(bus_b.oReady_AS_EnInoutState), 64'd1);
        tick();
        bus_b.iValid_AS_EnInoutState = 1'b0;
        #1;
        chk("w1_out2_valid", 64'(bus_b.oValid_BM_DecState), 64'd1);
        chk("w1_out2_data", 64'(bus_b.oData_BM_DecState), 64'h0101);
        tick();
        chk("w1_end", 64'(bus_b.oValid_BM_DecState), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
